// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake.
// Optional CTRL_PERF_CNT_EN adds retired/stall_cycles performance counters.
module ctrl_sequencer #(
  parameter int IW          = 9,
  parameter int AW          = 4,
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  instr,
  input  logic           instr_valid,
  input  logic           mem_ready,
  output logic           fetch_req,
  output logic           pc_en,
  output logic           branch,
  output logic           immed,
  output logic           alu_src,
  output logic           mem_to_reg,
  output logic           flag_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           reg_write,
  output logic [2:0]     flag,
  output logic [AW-1:0]  rd_addr_a,
  output logic [AW-1:0]  rd_addr_b,
  output logic [AW-1:0]  w_addr,
  output logic [OPW-1:0] alu_op,
  output logic           done,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0]    retired,
  output logic [31:0]    stall_cycles,
`endif
  output logic           err_timeout
);

  localparam int unsigned NR = 1 << AW;
  localparam logic [AW-1:0] RA = AW'(NR - 8);
  localparam logic [AW-1:0] RB = AW'(NR - 7);
  localparam logic [AW-1:0] RS = AW'(NR - 2);
  localparam logic [AW-1:0] RM = AW'(NR - 1);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_SHIFT, K_LOAD, K_STORE,
    K_LI, K_MOV, K_JUMP, K_FLAG, K_HALT
  } kind_t;

  state_t         state, nxt;
  kind_t          kind;
  logic [8:0]     op_q;
  logic [CW-1:0]  cnt_q;
  logic           err_q;
  logic           started_q;
  logic           act;
  logic           tmo;
  logic           d_br, d_im, d_as, d_mtr, d_fw;
  logic [2:0]     d_fl;
  logic [AW-1:0]  d_ra, d_rb, d_wa;
  logic [OPW-1:0] d_alu;

  if (IW > 9) begin : g_imm
    logic unused_imm;
    assign unused_imm = ^instr[IW-10:0];
  end

  // opcode classification and the controls each class drives
  always_comb begin
    kind  = K_NOP;
    d_br  = 1'b0;
    d_im  = 1'b0;
    d_as  = 1'b0;
    d_mtr = 1'b0;
    d_fw  = 1'b0;
    d_fl  = 3'b000;
    d_ra  = RA;
    d_rb  = RB;
    d_wa  = RM;
    d_alu = '0;
    unique case (1'b1)
      op_q[8]: begin
        if (op_q[7:0] == 8'hff) begin
          kind = K_HALT;
        end else begin
          kind  = K_MOV;
          d_ra  = AW'(op_q[3:0]);
          d_rb  = AW'(op_q[3:0]);
          d_wa  = AW'(op_q[7:4]);
          d_alu = OPW'(5'b00010);
        end
      end
      op_q[8:6] == 3'b010: begin
        kind = K_JUMP;
        d_br = 1'b1;
        d_im = 1'b1;
      end
      op_q[8:3] == 6'b000111: begin
        if (op_q[2:0] < 3'd5) begin
          kind = K_FLAG;
          d_fw = 1'b1;
          d_fl = op_q[2:0];
        end
      end
      op_q[8:6] == 3'b000 && op_q[5:3] != 3'b111: begin
        kind  = K_ALU;
        d_alu = OPW'(op_q[5:3]);
        d_wa  = AW'(op_q[2:0]);
      end
      op_q[8:4] == 5'b00100: begin
        kind  = K_SHIFT;
        d_alu = op_q[3] ? OPW'(5'b01111) : OPW'(5'b01110);
        d_as  = |op_q[2:0];
        d_wa  = RS;
      end
      op_q[8:4] == 5'b00101: begin
        kind  = op_q[3] ? K_STORE : K_LOAD;
        d_ra  = AW'(op_q[2:0]);
        d_rb  = AW'(op_q[2:0]);
        d_alu = OPW'(5'b00010);
        d_mtr = ~op_q[3];
      end
      op_q[8:5] == 4'b0110: begin
        kind = K_LI;
        d_im = 1'b1;
      end
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= nxt;
  end

  // instruction latch, memory wait counter, sticky timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
      err_q     <= err_q | tmo;
      if (state == S_FETCH && instr_valid)
        op_q <= instr[IW-1 -: 9];
      if (state == S_MEM && nxt == S_MEM)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
    end
  end

  // next state and per-state strobes
  always_comb begin
    nxt       = state;
    act       = 1'b0;
    tmo       = 1'b0;
    fetch_req = 1'b0;
    pc_en     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_FETCH: begin
        fetch_req = started_q;
        if (instr_valid) nxt = S_DECODE;
      end
      S_DECODE: begin
        act = 1'b1;
        nxt = S_EXEC;
      end
      S_EXEC: begin
        act = 1'b1;
        if (kind == K_LOAD || kind == K_STORE)
          nxt = S_MEM;
        else if (kind == K_HALT)
          nxt = S_HALT;
        else
          nxt = S_WB;
      end
      S_MEM: begin
        act       = 1'b1;
        mem_read  = (kind == K_LOAD);
        mem_write = (kind == K_STORE);
        if (mem_ready) begin
          nxt = S_WB;
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          tmo = 1'b1;
          nxt = S_HALT;
        end
      end
      S_WB: begin
        act       = 1'b1;
        pc_en     = 1'b1;
        reg_write = kind inside {K_ALU, K_SHIFT, K_LOAD,
                                 K_LI, K_MOV};
        nxt       = S_FETCH;
      end
      S_HALT: done = 1'b1;
      default: nxt = S_FETCH;
    endcase
  end

  assign branch      = act & d_br;
  assign immed       = act & d_im;
  assign alu_src     = act & d_as;
  assign mem_to_reg  = act & d_mtr;
  assign flag_write  = act & d_fw;
  assign flag        = act ? d_fl  : 3'b000;
  assign rd_addr_a   = act ? d_ra  : RA;
  assign rd_addr_b   = act ? d_rb  : RB;
  assign w_addr      = act ? d_wa  : RM;
  assign alu_op      = act ? d_alu : '0;
  assign err_timeout = err_q;

`ifdef CTRL_PERF_CNT_EN
  // saturating retire and stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (pc_en && retired != '1)
        retired <= retired + 32'd1;
      if (((state == S_MEM && !mem_ready) ||
           (state == S_FETCH && !instr_valid)) &&
          stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized bench for ctrl_sequencer against a per-instruction reference.
// Runs an AW=4 and an AW=6 instance in lockstep on the same opcodes.
module tb_ctrl_sequencer;

  localparam int K_NOP = 0;
  localparam int K_WR  = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;
  localparam int K_HLT = 4;

  typedef struct {
    bit       br, im, as, mtr, fw;
    bit [2:0] fl;
    int       ra, rb, wa, alu;
    int       kind;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  instr_a;
  logic [10:0] instr_b;
  logic        instr_valid;
  logic        mem_ready;

  logic fr_a, pc_a, br_a, im_a, as_a, mtr_a, fw_a;
  logic mr_a, mw_a, rw_a, dn_a, et_a;
  logic [2:0] fl_a;
  logic [3:0] ra_a, rb_a, wa_a;
  logic [4:0] op_a;

  logic fr_b, pc_b, br_b, im_b, as_b, mtr_b, fw_b;
  logic mr_b, mw_b, rw_b, dn_b, et_b;
  logic [2:0] fl_b;
  logic [5:0] ra_b, rb_b, wa_b;
  logic [4:0] op_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_sequencer u_a (
    .clk(clk), .rst(rst), .instr(instr_a),
    .instr_valid(instr_valid), .mem_ready(mem_ready),
    .fetch_req(fr_a), .pc_en(pc_a), .branch(br_a),
    .immed(im_a), .alu_src(as_a), .mem_to_reg(mtr_a),
    .flag_write(fw_a), .mem_read(mr_a), .mem_write(mw_a),
    .reg_write(rw_a), .flag(fl_a), .rd_addr_a(ra_a),
    .rd_addr_b(rb_a), .w_addr(wa_a), .alu_op(op_a),
    .done(dn_a), .err_timeout(et_a)
  );

  ctrl_sequencer #(.IW(11), .AW(6)) u_b (
    .clk(clk), .rst(rst), .instr(instr_b),
    .instr_valid(instr_valid), .mem_ready(mem_ready),
    .fetch_req(fr_b), .pc_en(pc_b), .branch(br_b),
    .immed(im_b), .alu_src(as_b), .mem_to_reg(mtr_b),
    .flag_write(fw_b), .mem_read(mr_b), .mem_write(mw_b),
    .reg_write(rw_b), .flag(fl_b), .rd_addr_a(ra_b),
    .rd_addr_b(rb_b), .w_addr(wa_b), .alu_op(op_b),
    .done(dn_b), .err_timeout(et_b)
  );

  function automatic exp_t idle(int aw);
    exp_t e;
    e.br = 0; e.im = 0; e.as = 0; e.mtr = 0; e.fw = 0;
    e.fl = 3'b000;
    e.ra = (1 << aw) - 8;
    e.rb = (1 << aw) - 7;
    e.wa = (1 << aw) - 1;
    e.alu = 0;
    e.kind = K_NOP;
    return e;
  endfunction

  // expected controls of one opcode, straight from the class table
  function automatic exp_t model(bit [8:0] op, int aw);
    exp_t e;
    int rs, rm;
    e = idle(aw);
    rs = (1 << aw) - 2;
    rm = (1 << aw) - 1;
    if (op[8]) begin
      if (op[7:0] == 8'hff) begin
        e.kind = K_HLT;
      end else begin
        e.ra = int'(op[3:0]);
        e.rb = int'(op[3:0]);
        e.wa = int'(op[7:4]);
        e.alu = 2;
        e.kind = K_WR;
      end
    end else if (op[8:6] == 3'b010) begin
      e.br = 1; e.im = 1;
    end else if (op[8:3] == 6'b000111) begin
      if (op[2:0] <= 3'd4) begin
        e.fw = 1; e.fl = op[2:0];
      end
    end else if (op[8:6] == 3'b000) begin
      if (op[5:3] != 3'b111) begin
        e.alu = int'(op[5:3]);
        e.wa = int'(op[2:0]);
        e.kind = K_WR;
      end
    end else if (op[8:4] == 5'b00100) begin
      e.alu = op[3] ? 15 : 14;
      e.as = (op[2:0] != 0);
      e.wa = rs;
      e.kind = K_WR;
    end else if (op[8:4] == 5'b00101) begin
      e.ra = int'(op[2:0]);
      e.rb = int'(op[2:0]);
      e.alu = 2;
      if (!op[3]) begin
        e.mtr = 1; e.wa = rm; e.kind = K_LD;
      end else begin
        e.kind = K_ST;
      end
    end else if (op[8:5] == 4'b0110) begin
      e.im = 1; e.wa = rm; e.kind = K_WR;
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // s = {fetch_req, pc_en, reg_write, mem_read,
  //      mem_write, done, err_timeout}
  task automatic look(string ph, bit act, exp_t ea,
                      exp_t eb, bit [6:0] s);
    exp_t xa, xb;
    xa = act ? ea : idle(4);
    xb = act ? eb : idle(6);
    chk({ph, " strobes.a"}, 32'({fr_a, pc_a, rw_a,
        mr_a, mw_a, dn_a, et_a}), 32'(s));
    chk({ph, " strobes.b"}, 32'({fr_b, pc_b, rw_b,
        mr_b, mw_b, dn_b, et_b}), 32'(s));
    chk({ph, " ctrl.a"}, 32'({br_a, im_a, as_a, mtr_a,
        fw_a, fl_a}), 32'({xa.br, xa.im, xa.as, xa.mtr,
        xa.fw, xa.fl}));
    chk({ph, " ctrl.b"}, 32'({br_b, im_b, as_b, mtr_b,
        fw_b, fl_b}), 32'({xb.br, xb.im, xb.as, xb.mtr,
        xb.fw, xb.fl}));
    chk({ph, " rd_addr_a.a"}, 32'(ra_a), xa.ra);
    chk({ph, " rd_addr_b.a"}, 32'(rb_a), xa.rb);
    chk({ph, " w_addr.a"}, 32'(wa_a), xa.wa);
    chk({ph, " alu_op.a"}, 32'(op_a), xa.alu);
    chk({ph, " rd_addr_a.b"}, 32'(ra_b), xb.ra);
    chk({ph, " rd_addr_b.b"}, 32'(rb_b), xb.rb);
    chk({ph, " w_addr.b"}, 32'(wa_b), xb.wa);
    chk({ph, " alu_op.b"}, 32'(op_b), xb.alu);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    instr_valid = 1'($urandom);
    instr_a = 9'($urandom);
    instr_b = 11'($urandom);
    mem_ready = 1'($urandom);
  endtask

  // async reset mid-cycle, checked while held and before first clock
  task automatic do_reset();
    exp_t z;
    z = idle(4);
    #2 rst = 1'b1;
    instr_valid = 1'b0;
    #1 look("reset", 0, z, z, 7'b0000000);
    @(negedge clk);
    rst = 1'b0;
    #1 look("released", 0, z, z, 7'b0000000);
    tick();
  endtask

  task automatic run(bit [8:0] op, int gap, int wt,
                     bit tmo, bit midrst);
    exp_t ea, eb;
    int n;
    bit ld, st, wr;
    ea = model(op, 4);
    eb = model(op, 6);
    ld = (ea.kind == K_LD);
    st = (ea.kind == K_ST);
    wr = (ea.kind == K_WR) || ld;
    for (int i = 0; i < gap; i++) begin
      noise();
      instr_valid = 1'b0;
      look("fetch-wait", 0, ea, eb, 7'b1000000);
      tick();
    end
    instr_valid = 1'b1;
    instr_a = op;
    instr_b = {op, 2'($urandom)};
    mem_ready = 1'($urandom);
    look("fetch", 0, ea, eb, 7'b1000000);
    tick();
    noise();
    look("decode", 1, ea, eb, 7'b0000000);
    tick();
    noise();
    look("exec", 1, ea, eb, 7'b0000000);
    tick();
    if (ea.kind == K_HLT) begin
      for (int i = 0; i < 3; i++) begin
        noise();
        look("halted", 0, ea, eb, 7'b0000010);
        tick();
      end
      do_reset();
      return;
    end
    if (ld || st) begin
      n = tmo ? 15 : wt + 1;
      for (int k = 0; k < n; k++) begin
        noise();
        mem_ready = !tmo && (k == n - 1);
        look("mem", 1, ea, eb, {3'b000, ld, st, 2'b00});
        if (midrst && k == 1) begin
          do_reset();
          return;
        end
        tick();
      end
      if (tmo) begin
        for (int i = 0; i < 3; i++) begin
          noise();
          look("timeout", 0, ea, eb, 7'b0000011);
          tick();
        end
        do_reset();
        return;
      end
    end
    noise();
    look("wb", 1, ea, eb, {1'b0, 1'b1, wr, 4'b0000});
    tick();
  endtask

  function automatic bit [8:0] rand_op();
    bit [8:0] op;
    case ($urandom_range(0, 9))
      0: op = {3'b000, 6'($urandom)};
      1: op = {6'b000111, 3'($urandom)};
      2: op = {5'b00100, 4'($urandom)};
      3: op = {5'b00101, 4'($urandom)};
      4: op = {4'b0110, 5'($urandom)};
      5: op = {3'b010, 6'($urandom)};
      6: op = {1'b1, 8'($urandom)};
      7: op = {1'b0, 1'($urandom), 2'b11, 5'($urandom)};
      8: op = 9'($urandom);
      default:
        op = ($urandom_range(0, 19) == 0) ? 9'h1ff
                                          : {3'b000, 6'($urandom)};
    endcase
    return op;
  endfunction

  initial begin
    bit [8:0] op;
    int gap, wt;
    bit tmo, mr;
    rst = 1'b1;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    instr_a = '0;
    instr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    run(9'b000_000_011, 0, 0, 0, 0);
    run(9'b0_0101_0_010, 0, 2, 0, 0);
    run(9'b000111_010, 1, 0, 0, 0);
    run(9'b000111_110, 0, 0, 0, 0);
    run(9'b00100_1_000, 0, 0, 0, 0);
    run(9'b0110_10101, 2, 0, 0, 0);
    run(9'b1_0011_1010, 0, 0, 0, 0);
    run(9'b0_0101_1_001, 0, 0, 0, 0);
    run(9'b0_0101_1_100, 0, 0, 1, 0);
    run(9'b0_0101_0_111, 0, 3, 0, 1);
    run(9'b1_1111_1111, 0, 0, 0, 0);
    for (int i = 0; i < 250; i++) begin
      op = rand_op();
      gap = $urandom_range(0, 2);
      wt = $urandom_range(0, 4);
      tmo = ($urandom_range(0, 15) == 0);
      mr = !tmo && wt >= 2 && ($urandom_range(0, 7) == 0);
      run(op, gap, wt, tmo, mr);
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
